// File: rtl/data_mem_arbiter_pkg.sv
// rtl/data_mem_arbiter_pkg.sv - shared types and constants for the data memory arbiter
package data_mem_arb_pkg;

    // Access sequencer states: accept, drive memory, return response
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_t;

    // Requester indices, also used as the owner / last_grant encoding
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // True when the byte address selects the first byte of a word
    function automatic logic word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - requester and memory-side signal bundle for the arbiter
interface data_mem_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) ();

    // Port A (core load/store path)
    logic                     mem_arb_a_req;
    logic                     mem_arb_a_we;
    logic [ADDRESS_WIDTH-1:0] mem_arb_a_addr;
    logic [DATA_WIDTH-1:0]    mem_arb_a_wdata;
    logic                     mem_arb_a_ready;
    logic                     mem_arb_a_rvalid;
    logic [DATA_WIDTH-1:0]    mem_arb_a_rdata;
    logic                     mem_arb_a_err;

    // Port B (debug / DMA loader)
    logic                     mem_arb_b_req;
    logic                     mem_arb_b_we;
    logic [ADDRESS_WIDTH-1:0] mem_arb_b_addr;
    logic [DATA_WIDTH-1:0]    mem_arb_b_wdata;
    logic                     mem_arb_b_ready;
    logic                     mem_arb_b_rvalid;
    logic [DATA_WIDTH-1:0]    mem_arb_b_rdata;
    logic                     mem_arb_b_err;

    // Single-port data memory side
    logic [ADDRESS_WIDTH-1:0] data_mem_addr;
    logic [DATA_WIDTH-1:0]    data_mem_in;
    logic                     data_mem_wr_en;
    logic [DATA_WIDTH-1:0]    data_mem_out;

    // Arbiter view
    modport slave (
        input  mem_arb_a_req, mem_arb_a_we, mem_arb_a_addr, mem_arb_a_wdata,
        output mem_arb_a_ready, mem_arb_a_rvalid, mem_arb_a_rdata, mem_arb_a_err,
        input  mem_arb_b_req, mem_arb_b_we, mem_arb_b_addr, mem_arb_b_wdata,
        output mem_arb_b_ready, mem_arb_b_rvalid, mem_arb_b_rdata, mem_arb_b_err,
        output data_mem_addr, data_mem_in, data_mem_wr_en,
        input  data_mem_out
    );

    // Requester / memory view
    modport master (
        output mem_arb_a_req, mem_arb_a_we, mem_arb_a_addr, mem_arb_a_wdata,
        input  mem_arb_a_ready, mem_arb_a_rvalid, mem_arb_a_rdata, mem_arb_a_err,
        output mem_arb_b_req, mem_arb_b_we, mem_arb_b_addr, mem_arb_b_wdata,
        input  mem_arb_b_ready, mem_arb_b_rvalid, mem_arb_b_rdata, mem_arb_b_err,
        input  data_mem_addr, data_mem_in, data_mem_wr_en,
        output data_mem_out
    );

endinterface

// File: rtl/data_mem_arbiter_rr_picker.sv
// rtl/data_mem_arbiter_rr_picker.sv - two-way round-robin grant picker (combinational)
module mem_arb_rr_picker
    import data_mem_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    output logic grant_a,
    output logic grant_b
);

    // A lone requester always wins; on a tie the port that was not served last wins
    always_comb begin
        grant_a = req_a && (!req_b || (last_grant == PORT_B));
        grant_b = req_b && (!req_a || (last_grant == PORT_A));
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin two-port arbiter for the single-port data memory (option: DATA_MEM_ARB_ALIGN_CHECK_EN)
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic              mem_arb_clk,
    input  logic              mem_arb_rst,
    data_mem_arbiter_if.slave bus
);

    arb_state_t               state_q;
    arb_state_t               state_d;
    logic                     owner_q;
    logic                     last_grant_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic                     wr_en_q;
    logic                     misalign_d;
    logic                     misalign_q;

    logic                     grant_a;
    logic                     grant_b;
    logic                     ready_a;
    logic                     ready_b;
    logic                     accept;
    logic                     accept_port;
    logic                     sel_we;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_wdata;

    logic                     rvalid_a;
    logic                     rvalid_b;
    logic [DATA_WIDTH-1:0]    rdata_a;
    logic [DATA_WIDTH-1:0]    rdata_b;
    logic                     err_a;
    logic                     err_b;

    mem_arb_rr_picker u_picker (
        .req_a      (bus.mem_arb_a_req),
        .req_b      (bus.mem_arb_b_req),
        .last_grant (last_grant_q),
        .grant_a    (grant_a),
        .grant_b    (grant_b)
    );

    // Winner's request fields, selected by the grant (at most one grant is high)
    always_comb begin
        accept      = ready_a || ready_b;
        accept_port = grant_b ? PORT_B : PORT_A;
        sel_we      = grant_b ? bus.mem_arb_b_we    : bus.mem_arb_a_we;
        sel_addr    = grant_b ? bus.mem_arb_b_addr  : bus.mem_arb_a_addr;
        sel_wdata   = grant_b ? bus.mem_arb_b_wdata : bus.mem_arb_a_wdata;
    end

`ifdef DATA_MEM_ARB_ALIGN_CHECK_EN
    // Misaligned accesses are accepted but never reach the memory as writes
    assign misalign_d = !word_aligned(sel_addr[1:0]);

    // Remember the misalignment of the access in flight for its response
    always_ff @(posedge mem_arb_clk) begin
        if (mem_arb_rst) begin
            misalign_q <= 1'b0;
        end else if (accept) begin
            misalign_q <= misalign_d;
        end
    end
`else
    assign misalign_d = 1'b0;
    assign misalign_q = 1'b0;
`endif

    // State register
    always_ff @(posedge mem_arb_clk) begin
        if (mem_arb_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: one accepted access walks IDLE -> ISSUE -> RESP -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Capture the winner into the memory-side registers; write enable lives only for ISSUE
    always_ff @(posedge mem_arb_clk) begin
        if (mem_arb_rst) begin
            owner_q      <= PORT_A;
            last_grant_q <= PORT_B;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_en_q      <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (accept) begin
                owner_q      <= accept_port;
                last_grant_q <= accept_port;
                addr_q       <= sel_addr;
                wdata_q      <= sel_wdata;
                wr_en_q      <= sel_we && !misalign_d;
            end
        end
    end

    // Handshake and response outputs; reset silences everything immediately
    always_comb begin
        ready_a  = 1'b0;
        ready_b  = 1'b0;
        rvalid_a = 1'b0;
        rvalid_b = 1'b0;
        rdata_a  = '0;
        rdata_b  = '0;
        err_a    = 1'b0;
        err_b    = 1'b0;
        if (!mem_arb_rst) begin
            case (state_q)
                ST_IDLE: begin
                    ready_a = grant_a;
                    ready_b = grant_b;
                end
                ST_RESP: begin
                    if (owner_q == PORT_A) begin
                        rvalid_a = 1'b1;
                        rdata_a  = misalign_q ? '0 : bus.data_mem_out;
                        err_a    = misalign_q;
                    end else begin
                        rvalid_b = 1'b1;
                        rdata_b  = misalign_q ? '0 : bus.data_mem_out;
                        err_b    = misalign_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_arb_a_ready  = ready_a;
    assign bus.mem_arb_a_rvalid = rvalid_a;
    assign bus.mem_arb_a_rdata  = rdata_a;
    assign bus.mem_arb_a_err    = err_a;
    assign bus.mem_arb_b_ready  = ready_b;
    assign bus.mem_arb_b_rvalid = rvalid_b;
    assign bus.mem_arb_b_rdata  = rdata_b;
    assign bus.mem_arb_b_err    = err_b;

    // A reset landing while ISSUE is in progress must keep that write out of the memory
    assign bus.data_mem_addr  = addr_q;
    assign bus.data_mem_in    = wdata_q;
    assign bus.data_mem_wr_en = wr_en_q && !mem_arb_rst;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int n_vec     = 0;
    int n_miscmp  = 0;

    int          wr_cnt   = 0;
    int          both_cnt = 0;
    logic        acc_port [$];
    int          acc_cyc  [$];
    logic        rv_port  [$];
    logic [31:0] rv_data  [$];

    data_mem_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) arb_bus ();

    data_mem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
        .mem_arb_clk (clk),
        .mem_arb_rst (rst),
        .bus         (arb_bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read data memory model; word i starts as 0xA0000000 + i
    logic [31:0] mem [0:63];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
        arb_bus.data_mem_out = '0;
        forever begin
            @(posedge clk);
            if (arb_bus.data_mem_wr_en) mem[arb_bus.data_mem_addr[7:2]] <= arb_bus.data_mem_in;
            arb_bus.data_mem_out <= mem[arb_bus.data_mem_addr[7:2]];
        end
    end

    // Event log sampled mid-cycle
    always @(negedge clk) begin
        if (arb_bus.data_mem_wr_en) wr_cnt++;
        if (arb_bus.mem_arb_a_req && arb_bus.mem_arb_a_ready) begin
            acc_port.push_back(1'b0);
            acc_cyc.push_back(cyc);
        end
        if (arb_bus.mem_arb_b_req && arb_bus.mem_arb_b_ready) begin
            acc_port.push_back(1'b1);
            acc_cyc.push_back(cyc);
        end
        if (arb_bus.mem_arb_a_ready && arb_bus.mem_arb_b_ready) both_cnt++;
        if (arb_bus.mem_arb_a_rvalid) begin
            rv_port.push_back(1'b0);
            rv_data.push_back(arb_bus.mem_arb_a_rdata);
        end
        if (arb_bus.mem_arb_b_rvalid) begin
            rv_port.push_back(1'b1);
            rv_data.push_back(arb_bus.mem_arb_b_rdata);
        end
        if (arb_bus.mem_arb_a_rvalid && arb_bus.mem_arb_b_rvalid) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit port, input bit req, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 1'b0) begin
            arb_bus.mem_arb_a_req   = req;
            arb_bus.mem_arb_a_we    = we;
            arb_bus.mem_arb_a_addr  = addr;
            arb_bus.mem_arb_a_wdata = wdata;
        end else begin
            arb_bus.mem_arb_b_req   = req;
            arb_bus.mem_arb_b_we    = we;
            arb_bus.mem_arb_b_addr  = addr;
            arb_bus.mem_arb_b_wdata = wdata;
        end
    endtask

    // One access on one port with the other idle; returns response and accept-to-rvalid latency
    task automatic do_access(input string tag, input bit port, input bit we,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic err, output int lat);
        bit got;
        int t_acc;
        @(posedge clk); #1;
        set_req(port, 1'b1, we, addr, wdata);
        got = 0;
        t_acc = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((port == 1'b0) ? arb_bus.mem_arb_a_ready : arb_bus.mem_arb_b_ready) begin
                got = 1;
                t_acc = cyc;
            end
        end
        chk({tag, "_accept"}, 32'(got), 32'd1);
        @(posedge clk); #1;
        set_req(port, 1'b0, 1'b0, addr, wdata);
        got = 0;
        rdata = '0;
        err = 1'b0;
        lat = -1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if ((port == 1'b0) ? arb_bus.mem_arb_a_rvalid : arb_bus.mem_arb_b_rvalid) begin
                got = 1;
                lat = cyc - t_acc;
                rdata = (port == 1'b0) ? arb_bus.mem_arb_a_rdata : arb_bus.mem_arb_b_rdata;
                err = (port == 1'b0) ? arb_bus.mem_arb_a_err : arb_bus.mem_arb_b_err;
            end
        end
        chk({tag, "_rvalid"}, 32'(got), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          w0;
        int          a0;
        int          r0;

        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        // 1: reset held with both requesting
        rst = 1'b1;
        set_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_ready_a", 32'(arb_bus.mem_arb_a_ready), 32'd0);
            chk("rst_ready_b", 32'(arb_bus.mem_arb_b_ready), 32'd0);
            chk("rst_wr_en",   32'(arb_bus.data_mem_wr_en),  32'd0);
            chk("rst_rvalid",  32'(arb_bus.mem_arb_a_rvalid | arb_bus.mem_arb_b_rvalid), 32'd0);
            chk("rst_addr",    arb_bus.data_mem_addr, 32'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("first_grant_a", 32'(arb_bus.mem_arb_a_ready), 32'd1);
        chk("first_grant_b", 32'(arb_bus.mem_arb_b_ready), 32'd0);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);

        // 2: A write then read back at 0x10
        w0 = wr_cnt;
        do_access("t2_wr", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
        chk("t2_wr_lat", 32'(lat), 32'd2);
        chk("t2_wr_err", 32'(er), 32'd0);
        chk("t2_wr_en_cycles", 32'(wr_cnt - w0), 32'd1);
        do_access("t2_rd", 1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat);
        chk("t2_rd_lat", 32'(lat), 32'd2);
        chk("t2_rd_data", rd, 32'hDEAD_BEEF);
        chk("t2_rd_err", 32'(er), 32'd0);
        chk("t2_rd_no_write", 32'(wr_cnt - w0), 32'd1);

        // 3: continuous requests from both; A was served last so B goes first
        @(posedge clk); #1;
        a0 = acc_port.size();
        r0 = rv_port.size();
        set_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        repeat (12) @(posedge clk);
        #1;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        chk("t3_accepts", 32'(acc_port.size() - a0), 32'd4);
        chk("t3_resps",   32'(rv_port.size() - r0), 32'd4);
        if (acc_port.size() >= a0 + 4 && rv_port.size() >= r0 + 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t3_grant%0d", i), 32'(acc_port[a0 + i]), 32'(i % 2 == 0));
                chk($sformatf("t3_rv_port%0d", i), 32'(rv_port[r0 + i]), 32'(i % 2 == 0));
                chk($sformatf("t3_rv_data%0d", i), rv_data[r0 + i],
                    (i % 2 == 0) ? 32'hA000_0008 : 32'hDEAD_BEEF);
            end
            for (int i = 1; i < 4; i++)
                chk($sformatf("t3_spacing%0d", i), 32'(acc_cyc[a0 + i] - acc_cyc[a0 + i - 1]), 32'd3);
        end

        // 4: B write at 0x40 wins the tie, A read of 0x40 follows in the next IDLE
        @(posedge clk); #1;
        a0 = acc_port.size();
        r0 = rv_port.size();
        set_req(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
        set_req(1'b1, 1'b1, 1'b1, 32'h40, 32'h1234_5678);
        @(negedge clk);
        chk("t4_ready_b", 32'(arb_bus.mem_arb_b_ready), 32'd1);
        chk("t4_ready_a", 32'(arb_bus.mem_arb_a_ready), 32'd0);
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_accepts", 32'(acc_port.size() - a0), 32'd2);
        chk("t4_resps",   32'(rv_port.size() - r0), 32'd2);
        if (acc_port.size() >= a0 + 2 && rv_port.size() >= r0 + 2) begin
            chk("t4_first_b",  32'(acc_port[a0]), 32'd1);
            chk("t4_then_a",   32'(acc_port[a0 + 1]), 32'd0);
            chk("t4_wait",     32'(acc_cyc[a0 + 1] - acc_cyc[a0]), 32'd3);
            chk("t4_rv_port",  32'(rv_port[r0 + 1]), 32'd0);
            chk("t4_rd_data",  rv_data[r0 + 1], 32'h1234_5678);
        end

        // 5: reset during ISSUE of a write to 0x80 must not touch memory or respond
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 1'b1, 32'h80, 32'h1111_1111);
        @(negedge clk);
        chk("t5_ready_a", 32'(arb_bus.mem_arb_a_ready), 32'd1);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        w0 = wr_cnt;
        r0 = rv_port.size();
        @(negedge clk);
        chk("t5_issue_wr_en", 32'(arb_bus.data_mem_wr_en), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t5_post_wr_en%0d", i), 32'(arb_bus.data_mem_wr_en), 32'd0);
            chk($sformatf("t5_post_rvalid%0d", i),
                32'(arb_bus.mem_arb_a_rvalid | arb_bus.mem_arb_b_rvalid), 32'd0);
        end
        chk("t5_no_write", 32'(wr_cnt - w0), 32'd0);
        chk("t5_no_resp",  32'(rv_port.size() - r0), 32'd0);
        do_access("t5_rd", 1'b0, 1'b0, 32'h80, 32'h0, rd, er, lat);
        chk("t5_rd_data", rd, 32'hA000_0020);

        // 6: misaligned write to 0x42
        w0 = wr_cnt;
        do_access("t6_wr", 1'b0, 1'b1, 32'h42, 32'hFFFF_FFFF, rd, er, lat);
`ifdef DATA_MEM_ARB_ALIGN_CHECK_EN
        chk("t6_err", 32'(er), 32'd1);
        chk("t6_rdata", rd, 32'h0);
        chk("t6_no_write", 32'(wr_cnt - w0), 32'd0);
        do_access("t6_rd", 1'b0, 1'b0, 32'h40, 32'h0, rd, er, lat);
        chk("t6_rd_data", rd, 32'h1234_5678);
`else
        chk("t6_err", 32'(er), 32'd0);
        chk("t6_one_write", 32'(wr_cnt - w0), 32'd1);
        do_access("t6_rd", 1'b0, 1'b0, 32'h40, 32'h0, rd, er, lat);
        chk("t6_rd_data", rd, 32'hFFFF_FFFF);
`endif
        chk("t6_rd_err", 32'(er), 32'd0);

        chk("never_both", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
